// File: rtl/serial_adder_n_if.sv
// Start/busy/done handshake and operand/result bus
// for the digit-serial adder.
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cOut;
  logic             ovf;

  modport master (
    output start, a, b, cIn,
    input  busy, done, s, cOut, ovf
  );

  modport slave (
    input  start, a, b, cIn,
    output busy, done, s, cOut, ovf
  );
endinterface

// File: rtl/serial_adder_n.sv
// Digit-serial adder: DIGIT bits per clock through a
// registered carry; result held until the next start.
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic             clk,
  input logic             rst_n,
  serial_adder_n_if.slave bus
);

  localparam int CYCLES = WIDTH / DIGIT;
  localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int ACC_W  = (WIDTH > DIGIT) ? WIDTH - DIGIT : 1;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_adder_n: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] sum_full;
  logic [ACC_W-1:0] acc_nx;
  logic             last;

  assign dsum = {1'b0, opa_q[DIGIT-1:0]}
              + {1'b0, opb_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};

  // sum_full is the complete sum once the final digit lands
  if (WIDTH > DIGIT) begin : g_acc
    assign sum_full = {dsum[DIGIT-1:0], acc_q};
    assign acc_nx   = sum_full[WIDTH-1:DIGIT];
  end else begin : g_noacc
    assign sum_full = dsum[DIGIT-1:0];
    assign acc_nx   = acc_q;
  end

  assign last = (cnt_q == CNT_W'(CYCLES - 1));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.start) begin
          state_d = RUN;
          opa_d   = bus.a;
          opb_d   = bus.b;
          carry_d = bus.cIn;
          cnt_d   = '0;
          acc_d   = '0;
          sa_d    = bus.a[WIDTH-1];
          sb_d    = bus.b[WIDTH-1];
        end
      end
      (state_q == RUN): begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        acc_d   = acc_nx;
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          state_d = IDLE;
          s_d     = sum_full;
          cout_d  = dsum[DIGIT];
          ovf_d   = (sa_q == sb_q)
                  && (sum_full[WIDTH-1] != sa_q);
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cOut = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: four configurations checked
// against a plain-arithmetic reference.
module tb_serial_adder_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          sel = 0;
  logic        start_v = 1'b0;
  logic [15:0] a_v = '0;
  logic [15:0] b_v = '0;
  logic        cin_v = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  int widths [4] = '{8, 8, 1, 16};
  int cycles [4] = '{8, 2, 1, 4};

  always #5 clk = ~clk;

  serial_adder_n_if #(.WIDTH(8))  if0 ();
  serial_adder_n_if #(.WIDTH(8))  if1 ();
  serial_adder_n_if #(.WIDTH(1))  if2 ();
  serial_adder_n_if #(.WIDTH(16)) if3 ();

  assign if0.start = start_v && (sel == 0);
  assign if0.a     = a_v[7:0];
  assign if0.b     = b_v[7:0];
  assign if0.cIn   = cin_v;
  assign if1.start = start_v && (sel == 1);
  assign if1.a     = a_v[7:0];
  assign if1.b     = b_v[7:0];
  assign if1.cIn   = cin_v;
  assign if2.start = start_v && (sel == 2);
  assign if2.a     = a_v[0];
  assign if2.b     = b_v[0];
  assign if2.cIn   = cin_v;
  assign if3.start = start_v && (sel == 3);
  assign if3.a     = a_v;
  assign if3.b     = b_v;
  assign if3.cIn   = cin_v;

  serial_adder_n #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  serial_adder_n #(.WIDTH(8), .DIGIT(4)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  serial_adder_n #(.WIDTH(1), .DIGIT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(if2));
  serial_adder_n #(.WIDTH(16), .DIGIT(4)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(if3));

  logic        o_busy, o_done, o_cout, o_ovf;
  logic [15:0] o_s;

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    o_cout = 1'b0;
    o_ovf  = 1'b0;
    o_s    = '0;
    case (sel)
      0: begin
        o_busy = if0.busy; o_done = if0.done;
        o_cout = if0.cOut; o_ovf  = if0.ovf;
        o_s    = {8'h00, if0.s};
      end
      1: begin
        o_busy = if1.busy; o_done = if1.done;
        o_cout = if1.cOut; o_ovf  = if1.ovf;
        o_s    = {8'h00, if1.s};
      end
      2: begin
        o_busy = if2.busy; o_done = if2.done;
        o_cout = if2.cOut; o_ovf  = if2.ovf;
        o_s    = {15'h0000, if2.s};
      end
      default: begin
        o_busy = if3.busy; o_done = if3.done;
        o_cout = if3.cOut; o_ovf  = if3.ovf;
        o_s    = if3.s;
      end
    endcase
  end

  // {ovf, cOut, s} from ordinary integer addition
  function automatic logic [17:0] ref_add(
    input int w, input logic [15:0] a, input logic [15:0] b,
    input logic ci);
    int unsigned m, full;
    logic [15:0] s;
    logic co, ov;
    m    = (32'd1 << w) - 32'd1;
    full = (32'(a) & m) + (32'(b) & m) + 32'(ci);
    s    = 16'(full & m);
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_add(input int d, input logic [15:0] a,
                        input logic [15:0] b, input logic ci,
                        input string tag);
    logic [17:0] e;
    int n;
    e = ref_add(widths[d], a, b, ci);
    @(negedge clk);
    sel = d; a_v = a; b_v = b; cin_v = ci; start_v = 1'b1;
    #1 chk({tag, " idle"}, 32'(o_busy), 32'd0);
    @(posedge clk);
    #1 start_v = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!o_done && n < 40);
    chk({tag, " lat"}, n, cycles[d]);
    chk({tag, " s"}, 32'(o_s), 32'(e[15:0]));
    chk({tag, " cout"}, 32'(o_cout), 32'(e[16]));
    chk({tag, " ovf"}, 32'(o_ovf), 32'(e[17]));
    chk({tag, " busy"}, 32'(o_busy), 32'd0);
    @(posedge clk);
    #1 chk({tag, " pulse"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    logic [17:0] e;
    logic [15:0] pa [4];
    logic [15:0] pb [4];
    logic        pc [4];
    int n, nd, at;
    logic [15:0] s_cap;

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int d = 0; d < 4; d++) begin
      sel = d;
      #1;
      chk("rst busy", 32'(o_busy), 32'd0);
      chk("rst done", 32'(o_done), 32'd0);
      chk("rst s", 32'(o_s), 32'd0);
      chk("rst cout", 32'(o_cout), 32'd0);
      chk("rst ovf", 32'(o_ovf), 32'd0);
    end

    do_add(0, 16'h00FF, 16'h0001, 1'b0, "w8 ff+01");
    do_add(0, 16'h007F, 16'h0001, 1'b0, "w8 7f+01");
    do_add(0, 16'h0080, 16'h0080, 1'b0, "w8 80+80");
    for (int i = 0; i < 6; i++)
      do_add(0, 16'($urandom), 16'($urandom), 1'($urandom),
             "w8 rand");

    do_add(1, 16'h00A5, 16'h005A, 1'b1, "w8d4 a5+5a+1");
    for (int i = 0; i < 4; i++)
      do_add(1, 16'($urandom), 16'($urandom), 1'($urandom),
             "w8d4 rand");

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      do_add(2, {15'h0, v[2]}, {15'h0, v[1]}, v[0], "w1 fa");
    end

    // starts while busy must be ignored
    e = ref_add(8, 16'h0012, 16'h0034, 1'b0);
    @(negedge clk);
    sel = 0; a_v = 16'h0012; b_v = 16'h0034;
    cin_v = 1'b0; start_v = 1'b1;
    @(posedge clk);
    #1 start_v = 1'b0;
    nd = 0; at = 0; s_cap = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start_v = (c == 2 || c == 4);
      a_v = 16'($urandom); b_v = 16'($urandom);
      @(posedge clk); #1;
      if (o_done) begin
        nd++; at = c; s_cap = o_s;
      end
    end
    start_v = 1'b0;
    chk("ign ndone", nd, 1);
    chk("ign at", at, 8);
    chk("ign s", 32'(s_cap), 32'(e[15:0]));
    chk("ign busy", 32'(o_busy), 32'd0);

    // async reset in the middle of an add
    @(negedge clk);
    sel = 0; a_v = 16'h0055; b_v = 16'h0022; start_v = 1'b1;
    @(posedge clk);
    #1 start_v = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("mid busy", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(o_busy), 32'd0);
    chk("arst done", 32'(o_done), 32'd0);
    chk("arst s", 32'(o_s), 32'd0);
    chk("arst cout", 32'(o_cout), 32'd0);
    chk("arst ovf", 32'(o_ovf), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (o_done) nd++;
    end
    chk("arst nodone", nd, 0);
    do_add(0, 16'h0033, 16'h0044, 1'b1, "w8 post rst");

    // start held high: back-to-back adds
    for (int j = 0; j < 4; j++) begin
      pa[j] = 16'($urandom);
      pb[j] = 16'($urandom);
      pc[j] = 1'($urandom);
    end
    @(negedge clk);
    sel = 3; a_v = pa[0]; b_v = pb[0];
    cin_v = pc[0]; start_v = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      e = ref_add(16, pa[j], pb[j], pc[j]);
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (!o_done && n < 40);
      chk("b2b lat", n, (j == 0) ? 4 : 5);
      chk("b2b s", 32'(o_s), 32'(e[15:0]));
      chk("b2b cout", 32'(o_cout), 32'(e[16]));
      chk("b2b ovf", 32'(o_ovf), 32'(e[17]));
      if (j < 3) begin
        a_v = pa[j+1]; b_v = pb[j+1]; cin_v = pc[j+1];
      end else begin
        start_v = 1'b0;
      end
    end
    @(posedge clk);
    #1 chk("b2b end busy", 32'(o_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
